// File: rtl/pp_uart_pkg.sv
// Shared types and defaults for the UART TX byte-stream arbiter.
package pp_uart_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StXfer = 1'b1
    } arb_state_e;

    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned IdleToDefault = 16;
    localparam int unsigned GrantW        = 3;

endpackage

// File: rtl/pp_rr_picker.sv
// Combinational round-robin picker: first requester at or after last_grant+1 (mod NUM_REQ).
module pp_rr_picker
    import pp_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GrantW-1:0]  last_grant,
    output logic               found,
    output logic [GrantW-1:0]  index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Offsets scanned nearest-first, so the first hit is the round-robin winner.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (32'(last_grant) + off) % NUM_REQ)) begin
                    found = 1'b1;
                    index = GrantW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/pp_uart_tx_arb.sv
// Arbitrates NUM_REQ byte streams onto a single UART TX FIFO write port with round-robin
// grants, per-grant burst limit and an idle timeout for stalled requesters.
module pp_uart_tx_arb
    import pp_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    parameter int unsigned IDLE_TO = IdleToDefault
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [7:0]             burst_max,
    input  logic                   uart_tx_fifo_full,
    output logic                   uart_tx_fifo_wreq,
    output logic [7:0]             uart_tx_fifo_wdata,
    output logic [GrantW-1:0]      grant_id,
    output logic                   busy
);

    localparam int unsigned IdleW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
    localparam logic [IdleW-1:0]  IdleMax    = IdleW'(IDLE_TO - 1);
    localparam logic [GrantW-1:0] LastGrRst  = GrantW'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [GrantW-1:0] grant_q, grant_d;
    logic [GrantW-1:0] last_grant_q, last_grant_d;
    logic [7:0]        burst_q, burst_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;

    logic              pick_found;
    logic [GrantW-1:0] pick_idx;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              xfer;
    logic              can_accept;
    logic              fire;
    logic              rel;

    pp_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GrantW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastGrRst;
            burst_q      <= '0;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        rel          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StXfer;
                    grant_d    = pick_idx;
                    burst_d    = burst_max;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            StXfer: begin
                if (fire) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    idle_cnt_d = '0;
                    if (sel_last || ((burst_q != 8'd0) && (byte_cnt_d == burst_q))) begin
                        rel = 1'b1;
                    end
                end else if (!sel_valid) begin
                    // Only an absent byte counts as idle; a FIFO-full stall never does.
                    if (idle_cnt_q == IdleMax) begin
                        rel = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                if (rel) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!soft_rst) begin
            state_d      = StIdle;
            grant_d      = '0;
            last_grant_d = LastGrRst;
            burst_d      = '0;
            byte_cnt_d   = '0;
            idle_cnt_d   = '0;
        end
    end

    always_comb begin
        xfer       = (state_q == StXfer);
        can_accept = xfer && soft_rst && !uart_tx_fifo_full;
        req_ready  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GrantW'(i)) begin
                req_ready[i] = can_accept;
            end
        end
        fire               = can_accept && sel_valid;
        uart_tx_fifo_wreq  = fire;
        uart_tx_fifo_wdata = xfer ? sel_data : 8'd0;
        grant_id           = grant_q;
        busy               = xfer;
    end

endmodule

// File: tb/tb_pp_uart_tx_arb.sv
// Directed self-checking bench for pp_uart_tx_arb with simple per-requester byte sources.
module tb_pp_uart_tx_arb;

    localparam int unsigned NReq = 4;

    logic            clk;
    logic            rst;
    logic            soft_rst;
    logic [NReq-1:0] req_valid;
    logic [NReq*8-1:0] req_data;
    logic [NReq-1:0] req_last;
    logic [NReq-1:0] req_ready;
    logic [7:0]      burst_max;
    logic            uart_tx_fifo_full;
    logic            uart_tx_fifo_wreq;
    logic [7:0]      uart_tx_fifo_wdata;
    logic [2:0]      grant_id;
    logic            busy;

    logic [7:0] src_len     [NReq];
    logic [7:0] src_ptr     [NReq];
    logic       src_en      [NReq];
    logic       src_last_en [NReq];
    logic       src_clr;

    logic [7:0] wlog [$];
    logic [2:0] glog [$];
    int         clog [$];
    int         cyc;
    int         n_run;
    int         n_fail;
    int         errs;

    pp_uart_tx_arb #(
        .NUM_REQ (NReq),
        .IDLE_TO (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .soft_rst           (soft_rst),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_last           (req_last),
        .req_ready          (req_ready),
        .burst_max          (burst_max),
        .uart_tx_fifo_full  (uart_tx_fifo_full),
        .uart_tx_fifo_wreq  (uart_tx_fifo_wreq),
        .uart_tx_fifo_wdata (uart_tx_fifo_wdata),
        .grant_id           (grant_id),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte i of requester r is {r, i}; last flag on the final byte when enabled.
    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NReq; i++) begin
            req_valid[i]       = src_en[i] && (src_ptr[i] < src_len[i]);
            req_last[i]        = src_last_en[i] && (src_ptr[i] == src_len[i] - 8'd1);
            req_data[8*i +: 8] = {4'(i), src_ptr[i][3:0]};
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NReq; i++) begin
            if (src_clr) src_ptr[i] <= 8'd0;
            else if (req_valid[i] && req_ready[i]) src_ptr[i] <= src_ptr[i] + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (uart_tx_fifo_wreq) begin
            wlog.push_back(uart_tx_fifo_wdata);
            glog.push_back(grant_id);
            clog.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int max_cyc);
        int k;
        k = 0;
        while (wlog.size() < n && k < max_cyc) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("write_count", 32'(wlog.size() >= n), 32'd1);
    endtask

    task automatic quiesce();
        for (int i = 0; i < NReq; i++) begin
            src_en[i]      = 1'b0;
            src_last_en[i] = 1'b0;
            src_len[i]     = 8'd0;
        end
        uart_tx_fifo_full = 1'b0;
        burst_max         = 8'd0;
        soft_rst          = 1'b0;
        src_clr           = 1'b1;
        step();
        soft_rst = 1'b1;
        src_clr  = 1'b0;
        wlog.delete();
        glog.delete();
        clog.delete();
        step();
    endtask

    logic [7:0] exp_b2 [10];
    logic [2:0] exp_g2 [10];

    initial begin
        n_run = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        soft_rst = 1'b1;
        burst_max = 8'd0;
        uart_tx_fifo_full = 1'b0;
        src_clr = 1'b1;
        for (int i = 0; i < NReq; i++) begin
            src_en[i] = 1'b0;
            src_last_en[i] = 1'b0;
            src_len[i] = 8'd0;
            src_ptr[i] = 8'd0;
        end
        exp_b2 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        exp_g2 = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};

        // Reset state
        #3;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wreq", 32'(uart_tx_fifo_wreq), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_wdata", 32'(uart_tx_fifo_wdata), 32'd0);
        step();
        step();
        rst = 1'b0;
        src_clr = 1'b0;
        step();

        // Two 3-byte messages, requesters 0 and 2
        src_len[0] = 8'd3; src_last_en[0] = 1'b1; src_en[0] = 1'b1;
        src_len[2] = 8'd3; src_last_en[2] = 1'b1; src_en[2] = 1'b1;
        wait_writes(6, 40);
        if (wlog.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("msg_byte", 32'(wlog[i]), (i < 3) ? 32'(i) : 32'h20 + 32'(i - 3));
                check_eq("msg_grant", 32'(glog[i]), (i < 3) ? 32'd0 : 32'd2);
            end
            check_eq("msg_gap01", 32'(clog[1] - clog[0]), 32'd1);
            check_eq("msg_gap23", 32'(clog[3] - clog[2]), 32'd2);
            check_eq("msg_gap45", 32'(clog[5] - clog[4]), 32'd1);
        end
        step();
        check_eq("msg_done_busy", 32'(busy), 32'd0);

        // Continuous requesters, burst_max=2
        quiesce();
        burst_max = 8'd2;
        for (int i = 0; i < NReq; i++) begin
            src_len[i] = 8'd200;
            src_en[i]  = 1'b1;
        end
        wait_writes(10, 80);
        if (wlog.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
                check_eq("burst_byte", 32'(wlog[i]), 32'(exp_b2[i]));
                check_eq("burst_grant", 32'(glog[i]), 32'(exp_g2[i]));
            end
        end

        // FIFO full for 30 cycles mid-message; burst_max change must not matter
        quiesce();
        src_len[1] = 8'd6; src_last_en[1] = 1'b1; src_en[1] = 1'b1;
        wait_writes(2, 20);
        step();
        uart_tx_fifo_full = 1'b1;
        burst_max = 8'd1;
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            if (uart_tx_fifo_wreq || !busy || req_ready != 4'b0000) errs++;
        end
        check_eq("full_stall", 32'(errs), 32'd0);
        check_eq("full_no_write", 32'(wlog.size()), 32'd2);
        step();
        uart_tx_fifo_full = 1'b0;
        wait_writes(6, 20);
        if (wlog.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("full_byte", 32'(wlog[i]), 32'h10 + 32'(i));
            end
        end
        step();
        check_eq("full_release", 32'(busy), 32'd0);

        // Idle timeout: requester 1 stops without last, requester 3 waiting
        quiesce();
        src_len[1] = 8'd2; src_en[1] = 1'b1;
        wait_writes(2, 20);
        step();
        src_len[3] = 8'd1; src_last_en[3] = 1'b1; src_en[3] = 1'b1;
        errs = 0;
        repeat (16) begin
            @(negedge clk);
            if (!busy) errs++;
        end
        check_eq("idle_hold", 32'(errs), 32'd0);
        @(negedge clk);
        check_eq("idle_release", 32'(busy), 32'd0);
        check_eq("idle_last_grant", 32'(grant_id), 32'd1);
        @(negedge clk);
        check_eq("idle_next_busy", 32'(busy), 32'd1);
        check_eq("idle_next_grant", 32'(grant_id), 32'd3);
        check_eq("idle_next_wdata", 32'(uart_tx_fifo_wdata), 32'h30);

        // Soft reset on a transfer cycle
        quiesce();
        src_len[1] = 8'd1; src_last_en[1] = 1'b1; src_en[1] = 1'b1;
        wait_writes(1, 10);
        step();
        src_en[1] = 1'b0;
        src_len[2] = 8'd10; src_en[2] = 1'b1;
        wait_writes(3, 20);
        step();
        soft_rst = 1'b0;
        src_len[0] = 8'd1; src_last_en[0] = 1'b1; src_en[0] = 1'b1;
        @(negedge clk);
        check_eq("srst_wreq", 32'(uart_tx_fifo_wreq), 32'd0);
        check_eq("srst_ready", 32'(req_ready), 32'd0);
        step();
        soft_rst = 1'b1;
        check_eq("srst_no_write", 32'(wlog.size()), 32'd3);
        @(negedge clk);
        check_eq("srst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("srst_regrant_busy", 32'(busy), 32'd1);
        check_eq("srst_regrant_id", 32'(grant_id), 32'd0);
        check_eq("srst_regrant_data", 32'(uart_tx_fifo_wdata), 32'h00);

        // Asynchronous reset mid-burst
        quiesce();
        src_len[0] = 8'd10; src_en[0] = 1'b1;
        src_len[1] = 8'd10; src_en[1] = 1'b1;
        wait_writes(2, 20);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_wreq", 32'(uart_tx_fifo_wreq), 32'd0);
        check_eq("arst_ready", 32'(req_ready), 32'd0);
        check_eq("arst_grant", 32'(grant_id), 32'd0);
        check_eq("arst_wdata", 32'(uart_tx_fifo_wdata), 32'd0);
        step();
        rst = 1'b0;
        wait_writes(3, 10);
        if (wlog.size() >= 3) begin
            check_eq("arst_regrant_id", 32'(glog[2]), 32'd0);
            check_eq("arst_resume_byte", 32'(wlog[2]), 32'h02);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pp_uart_tx_arb.md
PP_UART_TX_ARB -- requirements
Module: pp_uart_tx_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter IDLE_TO, default 16, giving the cycles a granted requester may hold the grant with no valid byte before release.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 soft_rst  input  1  synchronous, active-low soft reset.
REQ-006 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  per-requester end-of-message flag, qualified by req_valid.
REQ-009 req_ready  output  NUM_REQ  per-requester accept; a byte transfers when valid and ready are both high.
REQ-010 burst_max  input  8  maximum bytes per grant; 0 means unlimited.
REQ-011 uart_tx_fifo_full  input  1  UART TX FIFO full.
REQ-012 uart_tx_fifo_wreq  output  1  UART TX FIFO write strobe.
REQ-013 uart_tx_fifo_wdata  output  8  UART TX FIFO write data.
REQ-014 grant_id  output  3  index of the current or most recent grantee.
REQ-015 busy  output  1  high while a grant is held.

Function
REQ-016 The FSM SHALL have two states: IDLE and XFER.
REQ-017 In IDLE with any req_valid high, the block SHALL pick the first valid requester in round-robin order starting at last_grant+1 (mod NUM_REQ) and enter XFER on the next edge with grant_id set to that requester.
REQ-018 In IDLE, all req_ready bits and uart_tx_fifo_wreq SHALL be 0.
REQ-019 In XFER, only req_ready[grant_id] MAY be high, and it SHALL equal !uart_tx_fifo_full (combinational).
REQ-020 uart_tx_fifo_wreq SHALL equal req_valid[grant_id] & req_ready[grant_id] in XFER, with uart_tx_fifo_wdata = req_data[grant_id] in the same cycle; there is no added latency.
REQ-021 burst_max SHALL be sampled on entry to XFER, and a byte counter SHALL clear on entry to XFER.
REQ-022 XFER SHALL return to IDLE on the edge after a transfer with req_last=1, or after the transfer that makes the byte count equal the sampled burst_max (burst_max≠0).
REQ-023 On each return to IDLE, last_grant SHALL take the value of grant_id.
REQ-024 An idle counter SHALL increment each XFER cycle where req_valid[grant_id]=0 and clear on any transfer.
REQ-025 When the idle counter reaches IDLE_TO-1, the block SHALL return to IDLE on the next edge.
REQ-026 Cycles stalled by uart_tx_fifo_full with valid high SHALL NOT increment the idle counter; a full FIFO never causes release.
REQ-027 A requester that drops req_valid mid-message without req_last SHALL keep the grant until the idle timeout.
REQ-028 A requester that stays valid SHALL be re-grantable only after one IDLE cycle, and other valid requesters SHALL take precedence via the round-robin order.
REQ-029 A burst_max change during XFER SHALL NOT affect the current grant.
REQ-030 busy SHALL be 1 exactly when the state is XFER.

Reset
REQ-031 rst=1 SHALL asynchronously force state IDLE, byte and idle counters to 0, grant_id=0, and last_grant=NUM_REQ-1, so that requester 0 wins first.
REQ-032 As a consequence of REQ-031, all outputs SHALL be 0 during rst.
REQ-033 soft_rst=0 SHALL perform the same clearing synchronously, overriding any transfer in that cycle.
REQ-034 During soft_rst=0, req_ready and uart_tx_fifo_wreq SHALL be forced to 0 combinationally.
REQ-035 Reset mid-burst SHALL discard the grant, with no partial handshake or write strobe.

Structure
REQ-036 The state encoding, the NUM_REQ default and the IDLE_TO default SHALL reside in shared package pp_uart_pkg.
REQ-037 The round-robin selection SHALL be a sub-module pp_rr_picker (inputs: request vector, last_grant; outputs: found, index), combinational.

Verification
REQ-038 After reset, requesters 0 and 2 both send 3-byte messages (last on byte 3): FIFO receives 0's bytes then 2's, one byte/cycle, one IDLE gap between, grant_id 0 then 2.
REQ-039 All 4 requesters continuously valid with burst_max=2, no last: grant order 0,1,2,3,0; exactly 2 writes per grant.
REQ-040 uart_tx_fifo_full held 1 for 30 cycles mid-message with valid high: no write and no release; the message resumes intact when full drops.
REQ-041 Granted requester 1 drops valid for 16 cycles without last, with IDLE_TO=16: busy falls on cycle 16 and requester 3 (waiting) is granted next.
REQ-042 soft_rst=0 asserted on the cycle of a valid transfer: no uart_tx_fifo_wreq; next cycle state IDLE; the next grant goes to requester 0.
REQ-043 rst pulsed asynchronously mid-burst: all outputs 0 immediately; after release, normal arbitration starting at requester 0.
